// File: rtl/softex_tcdm_arbiter.sv
// softex_tcdm_arbiter
// Shares the single SoftEx TCDM initiator port between N_REQ internal
// requesters (in stream, out stream, slot load, slot store) with a
// round-robin pick. Outstanding reads are tracked in an in-order ID FIFO so
// every read response is routed back to the requester that issued it.
// Reads are held off while MAX_OUTSTANDING reads are already in flight.
//
// Ports:
//   clk_i, rst_ni, clear_i       clock, async active-low reset, sync soft clear
//   req_i/wen_i/add_i/data_i/be_i per-requester request (wen=1 read), packed by index
//   gnt_o                        one-hot grant, combinational from tcdm_gnt_i
//   r_valid_o, r_data_o          routed read-response valid / broadcast data
//   tcdm_*_o, tcdm_*_i           TCDM initiator port
//   outstanding_o                reads in flight
//   err_o                        sticky: response arrived with nothing outstanding
//
// Optional feature: define SOFTEX_TCDM_ARB_BURST_LOCK_EN to keep the pointer
// on a requester for up to 8 consecutive accepted beats while it keeps
// requesting (keeps streamer bursts contiguous).
module softex_tcdm_arbiter #(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned DATA_WIDTH      = 256,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      clear_i,
    input  logic [N_REQ-1:0]                          req_i,
    input  logic [N_REQ-1:0]                          wen_i,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]          add_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]          data_i,
    input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]        be_i,
    output logic [N_REQ-1:0]                          gnt_o,
    output logic [N_REQ-1:0]                          r_valid_o,
    output logic [DATA_WIDTH-1:0]                     r_data_o,
    output logic                                      tcdm_req_o,
    output logic                                      tcdm_wen_o,
    output logic [ADDR_WIDTH-1:0]                     tcdm_add_o,
    output logic [DATA_WIDTH-1:0]                     tcdm_data_o,
    output logic [DATA_WIDTH/8-1:0]                   tcdm_be_o,
    input  logic                                      tcdm_gnt_i,
    input  logic                                      tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                     tcdm_r_data_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding_o,
    output logic                                      err_o
);

    localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDW-1:0]                      rr_q, rr_d;
    logic [MAX_OUTSTANDING-1:0][IDW-1:0] fifo_q;
    logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                err_q, err_d;

    logic             full, empty, found, hs, push, pop;
    logic [N_REQ-1:0] elig;
    logic [IDW-1:0]   win, idx, win_inc, head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (cnt_q == '0);
    // Full blocks new reads even if a response pops in the same cycle.
    assign elig  = req_i & (~wen_i | {N_REQ{~full}});

    // Round-robin pick: first eligible requester at or after rr_q.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IDW'((32'(rr_q) + k) % N_REQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_inc = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign hs      = found & tcdm_gnt_i;

    assign tcdm_req_o  = found;
    assign tcdm_wen_o  = found & wen_i[win];
    assign tcdm_add_o  = found ? add_i[win]  : '0;
    assign tcdm_data_o = found ? data_i[win] : '0;
    assign tcdm_be_o   = found ? be_i[win]   : '0;

    always_comb begin
        gnt_o      = '0;
        gnt_o[win] = hs;
    end

    // Read tracking. A read accepted during clear is intentionally not recorded.
    assign push    = hs & wen_i[win] & ~clear_i;
    assign pop     = tcdm_r_valid_i & ~empty;
    assign head_id = fifo_q[rd_ptr_q];

    always_comb begin
        r_valid_o          = '0;
        r_valid_o[head_id] = pop;
    end

    assign r_data_o      = tcdm_r_data_i;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

`ifdef SOFTEX_TCDM_ARB_BURST_LOCK_EN
    logic [2:0] beat_q, beat_d, beat_prev;
`endif

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        err_d    = err_q | (tcdm_r_valid_i & empty);
        rr_d     = rr_q;
`ifdef SOFTEX_TCDM_ARB_BURST_LOCK_EN
        // beat_q counts consecutive accepted beats of the requester at rr_q.
        beat_d    = beat_q;
        beat_prev = (win == rr_q) ? beat_q : '0;
        if (hs) begin
            if (beat_prev == 3'd7) begin
                rr_d   = win_inc;
                beat_d = '0;
            end else begin
                rr_d   = win;
                beat_d = beat_prev + 3'd1;
            end
        end else if (!req_i[rr_q]) begin
            beat_d = '0;
        end
`else
        if (hs) rr_d = win_inc;
`endif
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
            rr_d     = '0;
`ifdef SOFTEX_TCDM_ARB_BURST_LOCK_EN
            beat_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) fifo_q[wr_ptr_q] <= win;
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

`ifdef SOFTEX_TCDM_ARB_BURST_LOCK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) beat_q <= '0;
        else         beat_q <= beat_d;
    end
`endif

    // Eligibility masks reads when full, so the FIFO can never overflow.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CNT_W'(MAX_OUTSTANDING));
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full));

endmodule

// File: tb/tb_softex_tcdm_arbiter.sv
// Bench for softex_tcdm_arbiter: directed scenarios followed by a random
// phase, all checked against a queue-based reference model of the arbiter.
module tb_softex_tcdm_arbiter;

    localparam int NR = 4;
    localparam int DW = 256;
    localparam int AW = 32;
    localparam int MO = 4;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n, clear, gnt_in, rvalid_in;
    logic [NR-1:0]           req, wen;
    logic [NR-1:0][AW-1:0]   add;
    logic [NR-1:0][DW-1:0]   wdata;
    logic [NR-1:0][BW-1:0]   be;
    logic [DW-1:0]           rdata;

    logic [NR-1:0]           gnt_o, r_valid_o;
    logic [DW-1:0]           r_data_o, tcdm_data_o;
    logic                    tcdm_req_o, tcdm_wen_o, err_o;
    logic [AW-1:0]           tcdm_add_o;
    logic [BW-1:0]           tcdm_be_o;
    logic [2:0]              outstanding_o;

    softex_tcdm_arbiter #(
        .N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .req_i(req), .wen_i(wen), .add_i(add), .data_i(wdata), .be_i(be),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_add_o(tcdm_add_o),
        .tcdm_data_o(tcdm_data_o), .tcdm_be_o(tcdm_be_o),
        .tcdm_gnt_i(gnt_in), .tcdm_r_valid_i(rvalid_in), .tcdm_r_data_i(rdata),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pointer, queue of in-flight read IDs, sticky error.
    int            m_rr;
    int            m_q[$];
    bit            m_err;
    int            m_beat;
    int            last_w;
    logic [NR-1:0] obs_gnt;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_q.delete();
        m_err = 1'b0;
        m_beat = 0;
    endtask

    task automatic rnd_payload();
        for (int i = 0; i < NR; i++) begin
            add[i] = $urandom;
            be[i]  = $urandom;
            for (int j = 0; j < DW / 32; j++) wdata[i][j*32 +: 32] = $urandom;
        end
        for (int j = 0; j < DW / 32; j++) rdata[j*32 +: 32] = $urandom;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        int            w;
        int            prev;
        bit            found, hs;
        logic [NR-1:0] eg, er;
        @(negedge clk);
        found = 1'b0;
        w = 0;
        for (int k = 0; k < NR; k++) begin
            int ix;
            ix = (m_rr + k) % NR;
            if (!found && req[ix] && (!wen[ix] || m_q.size() < MO)) begin
                found = 1'b1;
                w = ix;
            end
        end
        hs = found && gnt_in;
        eg = '0;
        if (hs) eg[w] = 1'b1;
        er = '0;
        if (rvalid_in && m_q.size() > 0) er[m_q[0]] = 1'b1;
        chk("tcdm_req", tcdm_req_o, found);
        chk("gnt", gnt_o, eg);
        chk("r_valid", r_valid_o, er);
        chk("r_data", r_data_o, rdata);
        chk("tcdm_wen", tcdm_wen_o, found ? wen[w] : 1'b0);
        chk("tcdm_add", tcdm_add_o, found ? add[w] : '0);
        chk("tcdm_data", tcdm_data_o, found ? wdata[w] : '0);
        chk("tcdm_be", tcdm_be_o, found ? be[w] : '0);
        chk("outstanding", outstanding_o, m_q.size());
        chk("err", err_o, m_err);
        obs_gnt = gnt_o;
        last_w  = hs ? w : -1;
        @(posedge clk);
        if (clear) begin
            model_reset();
        end else begin
            if (rvalid_in) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (hs) begin
                if (wen[w]) m_q.push_back(w);
`ifdef SOFTEX_TCDM_ARB_BURST_LOCK_EN
                prev = (w == m_rr) ? m_beat : 0;
                if (prev == 7) begin
                    m_rr = (w + 1) % NR;
                    m_beat = 0;
                end else begin
                    m_rr = w;
                    m_beat = prev + 1;
                end
            end else if (!req[m_rr]) begin
                m_beat = 0;
`else
                prev = 0;
                m_rr = (w + 1) % NR;
`endif
            end
        end
        #1;
    endtask

    initial begin
`ifdef SOFTEX_TCDM_ARB_BURST_LOCK_EN
        int n0;
        bit got3;
`endif
        rst_n = 1'b0; clear = 1'b0; gnt_in = 1'b0; rvalid_in = 1'b0;
        req = '0; wen = '0; add = '0; wdata = '0; be = '0; rdata = '0;
        model_reset();
        #2;
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_tcdm_req", tcdm_req_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fairness: everyone reads, responses one cycle after each grant.
        req = '1; wen = '1; gnt_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rvalid_in = (i > 0);
            rnd_payload();
            cyc();
`ifndef SOFTEX_TCDM_ARB_BURST_LOCK_EN
            chk("fair_order", last_w, i % 4);
`endif
        end
        req = '0; rvalid_in = 1'b1;
        cyc();
        rvalid_in = 1'b0;

        // Back-pressure: fill the FIFO, then a read waits while a write passes.
        req = '1; wen = '1;
        for (int i = 0; i < 4; i++) cyc();
        req = '0;
        chk("bp_outstanding_full", outstanding_o, 4);
        req = 4'b0110; wen = 4'b1101;
        cyc();
        chk("bp_write_granted", obs_gnt, 4'b0010);
        req = 4'b0100; rvalid_in = 1'b1;
        cyc();
        chk("bp_full_blocks_read", obs_gnt, 4'b0000);
        rvalid_in = 1'b0;
        cyc();
        chk("bp_read_after_pop", obs_gnt, 4'b0100);
        req = '0; rvalid_in = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        rvalid_in = 1'b0;

        // Push and pop in the same cycle.
        req = 4'b0001; wen = '1;
        cyc();
        cyc();
        rvalid_in = 1'b1;
        cyc();
        chk("pp_outstanding_hold", outstanding_o, 2);
        req = '0;
        cyc();
        cyc();
        rvalid_in = 1'b0;
        chk("pp_drained", outstanding_o, 0);

        // Stall: no grants while the port withholds tcdm_gnt_i.
        req = 4'b0110; wen = '0; gnt_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rnd_payload();
            cyc();
            chk("stall_no_gnt", obs_gnt, 4'b0000);
        end
        gnt_in = 1'b1;
        cyc();
        chk("stall_release_first", obs_gnt, 4'b0010);
        req = '0;

        // Spurious response, then clear with reads in flight and a read in the clear cycle.
        rvalid_in = 1'b1;
        cyc();
        rvalid_in = 1'b0;
        chk("spurious_err", err_o, 1);
        req = 4'b1000; wen = '1;
        cyc();
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0; req = '0;
        chk("clear_err", err_o, 0);
        chk("clear_outstanding", outstanding_o, 0);
        rvalid_in = 1'b1;
        cyc();
        rvalid_in = 1'b0;
        chk("post_clear_drop_err", err_o, 1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;

        // Asynchronous reset with reads in flight.
        req = 4'b0100; wen = '1;
        cyc();
        cyc();
        req = '0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_outstanding", outstanding_o, 0);
        chk("arst_err", err_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rvalid_in = 1'b1;
        cyc();
        rvalid_in = 1'b0;
        chk("post_arst_drop_err", err_o, 1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req       = NR'($urandom);
            wen       = NR'($urandom);
            gnt_in    = ($urandom % 10) < 7;
            rvalid_in = ($urandom % 10) < 4;
            clear     = ($urandom % 50) == 0;
            rnd_payload();
            cyc();
        end
        req = '0; rvalid_in = 1'b0; clear = 1'b1; gnt_in = 1'b1;
        cyc();
        clear = 1'b0;

`ifdef SOFTEX_TCDM_ARB_BURST_LOCK_EN
        // Burst lock: requester 0 keeps 8 beats, requester 3 gets the 9th.
        n0 = 0; got3 = 1'b0; wen = '0;
        for (int c = 0; c < 10; c++) begin
            req = {~got3, 2'b00, (n0 < 10)};
            cyc();
            chk("burst_order", last_w, (c == 8) ? 3 : 0);
            if (last_w == 0) n0++;
            if (last_w == 3) got3 = 1'b1;
        end
        req = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
